// File: rtl/video_mode_detect_pkg.sv
// Shared widths, limits, state encoding and
// helpers for the video timing detector.
package video_mode_detect_pkg;

  localparam int W    = 12;
  localparam int WDOG = 4096;

  localparam logic [W-1:0] SAT     = 12'd4095;
  localparam logic [W-1:0] WD_LAST = W'(WDOG - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED
  } state_e;

  typedef struct packed {
    logic [W-1:0] h_total;
    logic [W-1:0] h_active;
    logic [W-1:0] v_total;
    logic [W-1:0] v_active;
    logic         hs_pol;
    logic         vs_pol;
  } timing_t;

  function automatic logic [W-1:0] sat_inc(
    input logic [W-1:0] v,
    input logic         en
  );
    return (en && v != SAT) ? v + 12'd1 : v;
  endfunction

  // Mostly-high sync means active-low.
  function automatic logic pol_of(
    input logic [W-1:0] hi,
    input logic [W-1:0] tot
  );
    logic [W:0] twice;
    twice = {hi, 1'b0};
    return (twice > {1'b0, tot}) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/video_mode_detect_edge_sampler.sv
// Pixel-enable gated input registers and
// rising-edge strobes for hsync/vsync.
module video_edge_sampler
  import video_mode_detect_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  input  logic ce_pix,
  input  logic hsync,
  input  logic vsync,
  input  logic de,
  output logic smp,
  output logic hs,
  output logic vs,
  output logic de_s,
  output logic hs_rise,
  output logic vs_rise
);

  logic smp_q, smp_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  logic hs_p_q, hs_p_d;
  logic vs_p_q, vs_p_d;

  always_comb begin
    smp_d  = ce_pix;
    hs_d   = ce_pix ? hsync : hs_q;
    vs_d   = ce_pix ? vsync : vs_q;
    de_d   = ce_pix ? de : de_q;
    hs_p_d = smp_q ? hs_q : hs_p_q;
    vs_p_d = smp_q ? vs_q : vs_p_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      smp_q  <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      hs_p_q <= 1'b0;
      vs_p_q <= 1'b0;
    end else begin
      smp_q  <= smp_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      hs_p_q <= hs_p_d;
      vs_p_q <= vs_p_d;
    end
  end

  assign smp     = smp_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign de_s    = de_q;
  assign hs_rise = smp_q & hs_q & ~hs_p_q;
  assign vs_rise = smp_q & vs_q & ~vs_p_q;

endmodule

// File: rtl/video_mode_detect.sv
// Measures line/frame timing and sync polarity
// and publishes it once two frames agree.
module video_mode_detect
  import video_mode_detect_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        hs_pol,
  output logic        vs_pol,
  output logic        valid,
  output logic        changed
);

  logic smp, hs, vs, de_s, hs_rise, vs_rise;

  video_edge_sampler u_smp (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .smp     (smp),
    .hs      (hs),
    .vs      (vs),
    .de_s    (de_s),
    .hs_rise (hs_rise),
    .vs_rise (vs_rise)
  );

  logic [W-1:0] pix_cnt_q, pix_cnt_d;
  logic [W-1:0] hs_hi_q, hs_hi_d;
  logic [W-1:0] de_cnt_q, de_cnt_d;
  logic [W-1:0] ln_cnt_q, ln_cnt_d;
  logic [W-1:0] vs_hi_q, vs_hi_d;
  logic [W-1:0] act_cnt_q, act_cnt_d;
  logic [W-1:0] line_len_q, line_len_d;
  logic [W-1:0] line_act_q, line_act_d;
  logic         line_hs_q, line_hs_d;
  logic         primed_q, primed_d;

  logic [W-1:0] ln_nxt, vs_nxt, act_nxt;
  timing_t      cand;
  logic         cand_v;
  logic         wd;

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    hs_hi_d    = hs_hi_q;
    de_cnt_d   = de_cnt_q;
    ln_cnt_d   = ln_cnt_q;
    vs_hi_d    = vs_hi_q;
    act_cnt_d  = act_cnt_q;
    line_len_d = line_len_q;
    line_act_d = line_act_q;
    line_hs_d  = line_hs_q;
    primed_d   = primed_q;
    ln_nxt     = ln_cnt_q;
    vs_nxt     = vs_hi_q;
    act_nxt    = act_cnt_q;
    cand       = '0;
    cand_v     = 1'b0;
    wd         = 1'b0;
    if (smp) begin
      if (hs_rise) begin
        line_len_d = pix_cnt_q;
        line_hs_d  = pol_of(hs_hi_q, pix_cnt_q);
        if (de_cnt_q != '0) line_act_d = de_cnt_q;
        // The boundary sample opens the new line.
        pix_cnt_d = 12'd1;
        hs_hi_d   = {{(W-1){1'b0}}, hs};
        de_cnt_d  = {{(W-1){1'b0}}, de_s};
        ln_nxt    = sat_inc(ln_cnt_q, 1'b1);
        vs_nxt    = sat_inc(vs_hi_q, vs);
        act_nxt   = sat_inc(act_cnt_q, de_cnt_q != '0);
        wd        = (ln_cnt_q == SAT) && !vs_rise;
      end else begin
        pix_cnt_d = sat_inc(pix_cnt_q, 1'b1);
        hs_hi_d   = sat_inc(hs_hi_q, hs);
        de_cnt_d  = sat_inc(de_cnt_q, de_s);
        wd        = (pix_cnt_q == WD_LAST);
      end
      ln_cnt_d  = ln_nxt;
      vs_hi_d   = vs_nxt;
      act_cnt_d = act_nxt;
      if (vs_rise) begin
        cand.h_total  = line_len_d;
        cand.h_active = line_act_d;
        cand.v_total  = ln_nxt;
        cand.v_active = act_nxt;
        cand.hs_pol   = line_hs_d;
        cand.vs_pol   = pol_of(vs_nxt, ln_nxt);
        cand_v        = primed_q;
        primed_d      = 1'b1;
        ln_cnt_d      = '0;
        vs_hi_d       = '0;
        act_cnt_d     = '0;
      end
    end
    if (wd) begin
      pix_cnt_d  = '0;
      hs_hi_d    = '0;
      de_cnt_d   = '0;
      ln_cnt_d   = '0;
      vs_hi_d    = '0;
      act_cnt_d  = '0;
      line_len_d = '0;
      line_act_d = '0;
      line_hs_d  = 1'b0;
      primed_d   = 1'b0;
      cand_v     = 1'b0;
    end
  end

  state_e  state_q, state_d;
  timing_t stored_q, stored_d;
  timing_t out_q, out_d;
  logic    valid_q, valid_d;
  logic    changed_q, changed_d;

  always_comb begin
    state_d   = state_q;
    stored_d  = stored_q;
    out_d     = out_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    if (cand_v) begin
      unique case (state_q)
        ST_SEARCH: begin
          stored_d = cand;
          state_d  = ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (cand == stored_q) begin
            out_d     = cand;
            valid_d   = 1'b1;
            changed_d = 1'b1;
            state_d   = ST_LOCKED;
          end else begin
            stored_d = cand;
          end
        end
        ST_LOCKED: begin
          if (cand != out_q) begin
            stored_d = cand;
            valid_d  = 1'b0;
            state_d  = ST_CONFIRM;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    if (wd) begin
      state_d = ST_SEARCH;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pix_cnt_q  <= '0;
      hs_hi_q    <= '0;
      de_cnt_q   <= '0;
      ln_cnt_q   <= '0;
      vs_hi_q    <= '0;
      act_cnt_q  <= '0;
      line_len_q <= '0;
      line_act_q <= '0;
      line_hs_q  <= 1'b0;
      primed_q   <= 1'b0;
      state_q    <= ST_SEARCH;
      stored_q   <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      hs_hi_q    <= hs_hi_d;
      de_cnt_q   <= de_cnt_d;
      ln_cnt_q   <= ln_cnt_d;
      vs_hi_q    <= vs_hi_d;
      act_cnt_q  <= act_cnt_d;
      line_len_q <= line_len_d;
      line_act_q <= line_act_d;
      line_hs_q  <= line_hs_d;
      primed_q   <= primed_d;
      state_q    <= state_d;
      stored_q   <= stored_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
    end
  end

  assign h_total  = out_q.h_total;
  assign h_active = out_q.h_active;
  assign v_total  = out_q.v_total;
  assign v_active = out_q.v_active;
  assign hs_pol   = out_q.hs_pol;
  assign vs_pol   = out_q.vs_pol;
  assign valid    = valid_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench with a scoreboard of expected
// published timings, popped on each changed pulse.
module tb_video_mode_detect;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        hsync, vsync, de;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic        hs_pol, vs_pol, valid, changed;

  always #5 clk_sys = ~clk_sys;

  video_mode_detect dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .h_total  (h_total),
    .h_active (h_active),
    .v_total  (v_total),
    .v_active (v_active),
    .hs_pol   (hs_pol),
    .vs_pol   (vs_pol),
    .valid    (valid),
    .changed  (changed)
  );

  // Scaled-down modes: A/B active-low, C active-high.
  int   HT[3] = '{40, 42, 60};
  int   HA[3] = '{32, 26, 48};
  int   VT[3] = '{26, 26, 36};
  int   VA[3] = '{24, 24, 32};
  logic PL[3] = '{1'b0, 1'b0, 1'b1};

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  logic changed_prev = 1'b0;
  logic [49:0] sb[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] exp_of(input int m);
    return {12'(HT[m]), 12'(HA[m]), 12'(VT[m]),
            12'(VA[m]), PL[m], PL[m]};
  endfunction

  function automatic logic [49:0] obs_out();
    return {h_total, h_active, v_total, v_active,
            hs_pol, vs_pol};
  endfunction

  task automatic px(input logic h, input logic v,
                    input logic d, input int cediv);
    ce_pix = 1'b1;
    hsync  = h;
    vsync  = v;
    de     = d;
    @(posedge clk_sys);
    #1;
    ce_pix = 1'b0;
    repeat (cediv - 1) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic drive_lines(input int m, input int l0,
                             input int n, input int cediv);
    int y;
    logic ha, va, d;
    for (int l = l0; l < l0 + n; l++) begin
      y = (l + VA[m]) % VT[m];
      va = (y == VA[m]);
      for (int x = 0; x < HT[m]; x++) begin
        ha = (x >= HA[m] + 2) && (x < HA[m] + 6);
        d  = (x < HA[m]) && (y < VA[m]);
        px(PL[m] ? ha : ~ha, PL[m] ? va : ~va, d, cediv);
      end
    end
  endtask

  task automatic frames(input int m, input int n,
                        input int cediv);
    drive_lines(m, 0, n * VT[m], cediv);
  endtask

  always @(negedge clk_sys) begin
    if (changed) begin
      n_pulse++;
      chk("chg_width", 64'(changed_prev), 64'd0);
      chk("chg_valid", 64'(valid), 64'd1);
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        chk("sb_timing", 64'(obs_out()), 64'(sb.pop_front()));
      end
    end
    changed_prev <= changed;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset  = 1'b1;
    ce_pix = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    de     = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_outs", 64'(obs_out()), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_changed", 64'(changed), 64'd0);

    // Mode A locks on the third vsync edge.
    frames(0, 1, 1);
    chk("a_f1_valid", 64'(valid), 64'd0);
    frames(0, 1, 1);
    chk("a_f2_valid", 64'(valid), 64'd0);
    sb.push_back(exp_of(0));
    frames(0, 1, 1);
    chk("a_f3_valid", 64'(valid), 64'd1);
    chk("a_outs", 64'(obs_out()), 64'(exp_of(0)));
    chk("a_pulses", 64'(n_pulse), 64'd1);

    // Switch to mode B at a frame boundary.
    frames(1, 1, 1);
    chk("b_f1_valid", 64'(valid), 64'd0);
    chk("b_f1_hold", 64'(obs_out()), 64'(exp_of(0)));
    sb.push_back(exp_of(1));
    frames(1, 1, 1);
    chk("b_f2_valid", 64'(valid), 64'd0);
    frames(1, 1, 1);
    chk("b_f3_valid", 64'(valid), 64'd1);
    chk("b_pulses", 64'(n_pulse), 64'd2);

    // Line watchdog: hsync stuck high.
    repeat (4200) px(1'b1, 1'b1, 1'b0, 1);
    chk("wd_valid", 64'(valid), 64'd0);
    chk("wd_hold", 64'(obs_out()), 64'(exp_of(1)));
    chk("wd_pulses", 64'(n_pulse), 64'd2);
    sb.push_back(exp_of(1));
    frames(1, 2, 1);
    chk("wd_f2_valid", 64'(valid), 64'd0);
    frames(1, 1, 1);
    chk("wd_f3_valid", 64'(valid), 64'd1);
    chk("wd_pulses2", 64'(n_pulse), 64'd3);

    // Mode A at quarter-rate ce_pix.
    sb.push_back(exp_of(0));
    frames(0, 1, 4);
    chk("q_f1_valid", 64'(valid), 64'd0);
    frames(0, 1, 4);
    chk("q_f2_valid", 64'(valid), 64'd0);
    frames(0, 1, 4);
    chk("q_f3_valid", 64'(valid), 64'd1);
    chk("q_outs", 64'(obs_out()), 64'(exp_of(0)));

    // Long ce_pix stall must not trip the watchdog.
    drive_lines(0, 0, 10, 4);
    repeat (4500) @(posedge clk_sys);
    #1;
    chk("stall_valid", 64'(valid), 64'd1);
    drive_lines(0, 10, 16, 4);
    chk("stall_valid2", 64'(valid), 64'd1);
    chk("stall_pulses", 64'(n_pulse), 64'd4);

    // Mode C, active-high syncs.
    sb.push_back(exp_of(2));
    frames(2, 4, 1);
    chk("c_valid", 64'(valid), 64'd1);
    chk("c_pols", 64'({hs_pol, vs_pol}), 64'd3);
    chk("c_outs", 64'(obs_out()), 64'(exp_of(2)));

    // One-cycle reset mid-frame while locked.
    drive_lines(2, 0, 10, 1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("mid_rst_outs", 64'(obs_out()), 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    drive_lines(2, 10, VT[2] - 10, 1);
    sb.push_back(exp_of(2));
    frames(2, 2, 1);
    chk("r_f2_valid", 64'(valid), 64'd0);
    frames(2, 1, 1);
    chk("r_f3_valid", 64'(valid), 64'd1);
    chk("r_outs", 64'(obs_out()), 64'(exp_of(2)));

    repeat (4) @(negedge clk_sys);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("pulses_total", 64'(n_pulse), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mode_detect.md
VIDEO_MODE_DETECT -- requirements
Module: video_mode_detect

Interface
REQ-001 SHALL have port clk_sys, input, 1, system clock; sole clock domain.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset sampled on clk_sys rising edge.
REQ-003 SHALL have port ce_pix, input, 1, pixel enable; all video inputs are sampled only on cycles with ce_pix=1.
REQ-004 SHALL have ports hsync, vsync, de, input, 1 each, raw sync of unknown polarity plus data-enable (=~(HBlank|VBlank)).
REQ-005 SHALL have ports h_total, h_active, v_total, v_active, output, 12 each, measured pixels/line, active pixels/line, lines/frame, active lines/frame.
REQ-006 SHALL have ports hs_pol, vs_pol, output, 1 each, sync polarity: 1 = active-high, 0 = active-low.
REQ-007 SHALL have port valid, output, 1, timing stable and outputs meaningful.
REQ-008 SHALL have port changed, output, 1, single-cycle pulse when any published value updates.

Function
REQ-009 SHALL register hsync/vsync/de on ce_pix cycles and detect rising edges against the previously sampled value; edges are visible only on ce_pix cycles.
REQ-010 SHALL treat each hsync rising edge as a line boundary and each vsync rising edge as a frame boundary, regardless of polarity.
REQ-011 SHALL count ce_pix samples per line (pix_cnt), samples with hsync=1 (hs_hi) and samples with de=1 (de_cnt); all counters saturate at 4095.
REQ-012 At each line boundary SHALL latch line_len=pix_cnt, line_hs=(2*hs_hi > pix_cnt) ? 0 : 1, and, if de_cnt≠0, line_act=de_cnt; then clear pix_cnt, hs_hi, de_cnt.
REQ-013 SHALL count lines per frame (ln_cnt), lines with vsync=1 at their boundary (vs_hi), and lines with de_cnt≠0 (act_cnt); saturate at 4095.
REQ-014 At each frame boundary SHALL form a candidate {line_len, line_act, ln_cnt, act_cnt, line_hs, vs_pol=(2*vs_hi > ln_cnt)?0:1}; then clear the frame counters.
REQ-015 State machine SEARCH -> CONFIRM -> LOCKED: SEARCH captures the first candidate and moves to CONFIRM; CONFIRM compares the next candidate; equal -> LOCKED, differ -> stay in CONFIRM with the new candidate stored.
REQ-016 On entering LOCKED SHALL copy the candidate to outputs, assert valid, and pulse changed for exactly one clk_sys cycle, 1 cycle after the confirming frame boundary.
REQ-017 In LOCKED, a candidate differing from the outputs SHALL deassert valid on the next cycle and move to CONFIRM with that candidate; outputs hold their previous values until re-locked.
REQ-018 Watchdog: no line boundary for 4096 ce_pix samples, or no frame boundary for 4096 lines, SHALL force SEARCH and valid=0 and clear all counters; outputs hold.
REQ-019 Simultaneous hsync and vsync edges on the same sample SHALL process the line boundary first, so the completed line counts toward the ending frame.
REQ-020 The first partial frame after reset or watchdog SHALL be discarded: the first frame boundary only clears counters, and candidates start from the second.
REQ-021 ce_pix=0 SHALL freeze all counters; a stuck ce_pix=0 never fires the watchdog.

Reset
REQ-022 reset SHALL set state=SEARCH, valid=0, changed=0, all counters and outputs to 0, hs_pol=vs_pol=0, and the previous-sample registers to 0.
REQ-023 reset asserted mid-frame or mid-lock SHALL take effect on the next clk_sys edge and override any simultaneous boundary event.

Structure
REQ-024 A shared package SHALL hold the 12-bit width constant, the 4095 saturation limit, the watchdog limit, and the state enum.
REQ-025 One sub-module video_edge_sampler SHALL own the ce_pix-gated input registers and edge pulses; all measurement logic stays in the top.

Verification
REQ-026 320x240 active, h_total 400, v_total 262, HS/VS active-low -> valid=1 at the 3rd vsync edge; outputs 400/320/262/240, hs_pol=0, vs_pol=0; changed pulses once.
REQ-027 Same timing, then switch at a frame boundary to h_total 424 / h_active 256 -> valid=0 within 1 frame, re-lock 2 frames later with 424/256, one changed pulse.
REQ-028 Active-high syncs, 640x480 in 800x525 -> hs_pol=1, vs_pol=1, correct totals.
REQ-029 Stop hsync toggling for 4096 ce_pix samples while LOCKED -> valid=0, outputs unchanged, state SEARCH.
REQ-030 ce_pix at 1/4 rate with identical pixel timing -> same measured values as full-rate ce_pix.
REQ-031 Assert reset for 1 cycle mid-frame while LOCKED -> all outputs 0 on the next cycle; re-lock after 3 further vsync edges.
